data_mem_resp: RTL and testbench

- Data-memory responder: the target end of the core's load/store port (req / we / size / addr / wd / rd).
- Accepts one request at a time and holds the core with `stall_o` for a fixed, parameterised wait.
- Performs byte, halfword or word stores with lane placement.
- Returns loads with sign or zero extension.
- Contains its own word-organised RAM; sits between the core and the data address space.

---
 rtl/data_mem_resp_if.sv | 21 ++
 rtl/data_mem_resp.sv | 172 +++++++++++++++++
 tb/tb_data_mem_resp.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_resp_if.sv
// Load/store port between the core (master) and the data-memory responder (slave).
interface data_mem_resp_if;
    logic        mem_req_i;
    logic        mem_we_i;
    logic [2:0]  mem_size_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_wd_i;
    logic [31:0] mem_rd_o;
    logic        stall_o;
    logic        err_o;

    modport master (
        output mem_req_i, mem_we_i, mem_size_i, mem_addr_i, mem_wd_i,
        input  mem_rd_o, stall_o, err_o
    );

    modport slave (
        input  mem_req_i, mem_we_i, mem_size_i, mem_addr_i, mem_wd_i,
        output mem_rd_o, stall_o, err_o
    );
endinterface

// File: rtl/data_mem_resp.sv
// Data-memory responder: single-outstanding load/store target with a fixed wait,
// byte/halfword lane placement on stores and sign/zero extension on loads.
module data_mem_resp #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    data_mem_resp_if.slave bus
);

    localparam int unsigned ADDR_W = $clog2(DEPTH_WORDS);
    localparam int unsigned LA_W   = ADDR_W + 2;
    localparam int unsigned CNT_W  = (WAIT_CYCLES == 0) ? 1 : $clog2(WAIT_CYCLES + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [2:0] SZ_B  = 3'd0;
    localparam logic [2:0] SZ_H  = 3'd1;
    localparam logic [2:0] SZ_W  = 3'd2;
    localparam logic [2:0] SZ_BU = 3'd4;
    localparam logic [2:0] SZ_HU = 3'd5;

    logic [1:0]       r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             w_latch;

    logic             r_we;
    logic [2:0]       r_size;
    logic [LA_W-1:0]  r_addr;
    logic [31:0]      r_wd;

    logic [3:0][7:0]  r_mem [DEPTH_WORDS];
    logic [31:0]      r_rd;
    logic             r_err;

    logic             w_access;
    logic             w_err;
    logic             w_wr_en;
    logic [ADDR_W-1:0] w_idx;
    logic [3:0]       w_be;
    logic [3:0][7:0]  w_wdata;
    logic [3:0][7:0]  w_word;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic [31:0]      w_load;
    logic             w_unused_addr;

    assign w_unused_addr = ^bus.mem_addr_i[31:LA_W];

    // State register and wait counter
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic; RESP ignores req since the core still shows the same instruction
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_latch     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.mem_req_i) begin
                    w_latch     = 1'b1;
                    w_cnt_nxt   = CNT_W'(WAIT_CYCLES);
                    w_state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                if (r_cnt != '0) w_cnt_nxt   = r_cnt - 1'b1;
                else             w_state_nxt = S_RESP;
            end
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Request capture; only the in-range address bits are kept so addresses wrap
    always_ff @(posedge clk_i) begin
        if (w_latch) begin
            r_we   <= bus.mem_we_i;
            r_size <= bus.mem_size_i;
            r_addr <= bus.mem_addr_i[LA_W-1:0];
            r_wd   <= bus.mem_wd_i;
        end
    end

    assign w_access = (r_state == S_BUSY) && (r_cnt == '0);
    assign w_idx    = r_addr[LA_W-1:2];

    // Legality: illegal size, misalignment, or unsigned size used for a store
    always_comb begin
        w_err = 1'b1;
        case (r_size)
            SZ_B:    w_err = 1'b0;
            SZ_BU:   w_err = r_we;
            SZ_H:    w_err = r_addr[0];
            SZ_HU:   w_err = r_we | r_addr[0];
            SZ_W:    w_err = |r_addr[1:0];
            default: w_err = 1'b1;
        endcase
    end

    // Store lane placement
    always_comb begin
        w_be    = 4'b0000;
        w_wdata = r_wd;
        case (r_size)
            SZ_B: begin
                w_be    = 4'b0001 << r_addr[1:0];
                w_wdata = {4{r_wd[7:0]}};
            end
            SZ_H: begin
                w_be    = r_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{r_wd[15:0]}};
            end
            SZ_W:    w_be = 4'b1111;
            default: w_be = 4'b0000;
        endcase
    end

    assign w_wr_en = w_access && r_we && !w_err && rst_ni;

    always_ff @(posedge clk_i) begin
        if (w_wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) r_mem[w_idx][i] <= w_wdata[i];
            end
        end
    end

    // Load path: array is read only on the access cycle
    assign w_word = w_access ? r_mem[w_idx] : '0;
    assign w_byte = w_word[r_addr[1:0]];
    assign w_half = r_addr[1] ? w_word[3:2] : w_word[1:0];

    always_comb begin
        w_load = '0;
        case (r_size)
            SZ_B:    w_load = {{24{w_byte[7]}}, w_byte};
            SZ_BU:   w_load = {24'h0, w_byte};
            SZ_H:    w_load = {{16{w_half[15]}}, w_half};
            SZ_HU:   w_load = {16'h0, w_half};
            SZ_W:    w_load = w_word;
            default: w_load = '0;
        endcase
    end

    // Response registers: rd holds between accesses, err is a one-cycle pulse in RESP
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_rd  <= '0;
            r_err <= 1'b0;
        end else begin
            r_err <= w_access && w_err;
            if (w_access) r_rd <= (r_we || w_err) ? 32'h0 : w_load;
        end
    end

    assign bus.mem_rd_o = r_rd;
    assign bus.err_o    = r_err;
    assign bus.stall_o  = rst_ni && ((r_state == S_IDLE) ? bus.mem_req_i : (r_state == S_BUSY));

endmodule

// File: tb/tb_data_mem_resp.sv
// Scoreboard bench for data_mem_resp: drivers queue expected responses, one monitor checks them.
module tb_data_mem_resp;

    typedef struct packed {
        logic [31:0] rd;
        logic        err;
        logic [31:0] stalls;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    data_mem_resp_if bus0 ();
    data_mem_resp_if bus1 ();
    data_mem_resp_if bus2 ();

    data_mem_resp #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1)) u_dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus0));
    data_mem_resp #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u_w0  (.clk_i(clk), .rst_ni(rst_n), .bus(bus1));
    data_mem_resp #(.DEPTH_WORDS(1024), .WAIT_CYCLES(4)) u_w4  (.clk_i(clk), .rst_ni(rst_n), .bus(bus2));

    exp_t q_main[$];
    exp_t q_w0[$];
    exp_t q_w4[$];

    int   checks = 0;
    int   errors = 0;
    bit   done   = 1'b0;
    logic prev_stall [3];
    int   scnt [3];
    logic prev_rst = 1'b1;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endfunction

    // Per-port monitor step: a falling stall edge marks the response cycle
    function automatic void mon_port(input int k, input logic st, input logic [31:0] rd, input logic er);
        exp_t e;
        bit   have;
        if (!rst_n) begin
            check($sformatf("stall_in_reset[%0d]", k), 32'(st), 32'h0);
            if (!prev_rst) begin
                check($sformatf("rd_reset[%0d]", k), rd, 32'h0);
                check($sformatf("err_reset[%0d]", k), 32'(er), 32'h0);
            end
            prev_stall[k] = 1'b0;
            scnt[k] = 0;
            return;
        end
        if (prev_stall[k] && !st) begin
            have = 1'b0;
            e    = '0;
            case (k)
                0: if (q_main.size() > 0) begin e = q_main.pop_front(); have = 1'b1; end
                1: if (q_w0.size() > 0)   begin e = q_w0.pop_front();   have = 1'b1; end
                default: if (q_w4.size() > 0) begin e = q_w4.pop_front(); have = 1'b1; end
            endcase
            if (!have) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp[%0d]: got response rd=0x%08h err=%0b with nothing expected", k, rd, er);
            end else begin
                check($sformatf("rd[%0d]", k), rd, e.rd);
                check($sformatf("err[%0d]", k), 32'(er), 32'(e.err));
                check($sformatf("stall_cycles[%0d]", k), 32'(scnt[k]), e.stalls);
            end
            scnt[k] = 0;
        end else begin
            check($sformatf("err_outside_resp[%0d]", k), 32'(er), 32'h0);
            if (st) scnt[k]++;
        end
        prev_stall[k] = st;
    endfunction

    initial begin
        for (int k = 0; k < 3; k++) begin
            prev_stall[k] = 1'b0;
            scnt[k] = 0;
        end
        while (!done) begin
            @(negedge clk);
            #2;
            mon_port(0, bus0.stall_o, bus0.mem_rd_o, bus0.err_o);
            mon_port(1, bus1.stall_o, bus1.mem_rd_o, bus1.err_o);
            mon_port(2, bus2.stall_o, bus2.mem_rd_o, bus2.err_o);
            prev_rst = rst_n;
        end
        check("pending_main", 32'(q_main.size()), 32'h0);
        check("pending_w0", 32'(q_w0.size()), 32'h0);
        check("pending_w4", 32'(q_w4.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // One core transaction on the WAIT_CYCLES=1 port; hold keeps req high through RESP
    task automatic do_main(input logic we, input logic [2:0] sz, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                           input bit hold = 1'b0);
        exp_t e;
        bit   fin;
        @(negedge clk);
        bus0.mem_we_i   = we;
        bus0.mem_size_i = sz;
        bus0.mem_addr_i = addr;
        bus0.mem_wd_i   = wd;
        bus0.mem_req_i  = 1'b1;
        e.rd = exp_rd; e.err = exp_err; e.stalls = 32'd3;
        q_main.push_back(e);
        fin = 1'b0;
        for (int n = 0; n < 20 && !fin; n++) begin
            @(negedge clk);
            #1;
            if (!bus0.stall_o) fin = 1'b1;
        end
        if (!fin) begin
            $display("FAIL main_timeout: stall_o still high at addr 0x%08h", addr);
            $fatal(1);
        end
        if (!hold) bus0.mem_req_i = 1'b0;
    endtask

    // Same request on the WAIT_CYCLES=0 and WAIT_CYCLES=4 ports in parallel
    task automatic do_sweep(input logic we, input logic [2:0] sz, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [31:0] exp_rd);
        exp_t e;
        bit   f1, f2;
        @(negedge clk);
        bus1.mem_we_i = we; bus1.mem_size_i = sz; bus1.mem_addr_i = addr; bus1.mem_wd_i = wd;
        bus2.mem_we_i = we; bus2.mem_size_i = sz; bus2.mem_addr_i = addr; bus2.mem_wd_i = wd;
        bus1.mem_req_i = 1'b1;
        bus2.mem_req_i = 1'b1;
        e.rd = exp_rd; e.err = 1'b0;
        e.stalls = 32'd2; q_w0.push_back(e);
        e.stalls = 32'd6; q_w4.push_back(e);
        f1 = 1'b0; f2 = 1'b0;
        for (int n = 0; n < 30 && !(f1 && f2); n++) begin
            @(negedge clk);
            #1;
            if (!f1 && !bus1.stall_o) begin f1 = 1'b1; bus1.mem_req_i = 1'b0; end
            if (!f2 && !bus2.stall_o) begin f2 = 1'b1; bus2.mem_req_i = 1'b0; end
        end
        if (!(f1 && f2)) begin
            $display("FAIL sweep_timeout: w0 done=%0b w4 done=%0b", f1, f2);
            $fatal(1);
        end
    endtask

    initial begin
        bus0.mem_req_i = 1'b1;
        bus0.mem_we_i = 1'b0; bus0.mem_size_i = 3'd2; bus0.mem_addr_i = '0; bus0.mem_wd_i = '0;
        bus1.mem_req_i = 1'b0;
        bus1.mem_we_i = 1'b0; bus1.mem_size_i = 3'd2; bus1.mem_addr_i = '0; bus1.mem_wd_i = '0;
        bus2.mem_req_i = 1'b0;
        bus2.mem_we_i = 1'b0; bus2.mem_size_i = 3'd2; bus2.mem_addr_i = '0; bus2.mem_wd_i = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        bus0.mem_req_i = 1'b0;

        // word, byte lanes
        do_main(1, 3'd2, 32'h10, 32'hDEADBEEF, 32'h0, 0);
        do_main(0, 3'd2, 32'h10, 32'h0, 32'hDEADBEEF, 0);
        do_main(1, 3'd0, 32'h13, 32'h000000A5, 32'h0, 0);
        do_main(0, 3'd2, 32'h10, 32'h0, 32'hA5ADBEEF, 0);
        do_main(0, 3'd0, 32'h13, 32'h0, 32'hFFFFFFA5, 0);
        do_main(0, 3'd4, 32'h13, 32'h0, 32'h000000A5, 0);
        do_main(0, 3'd0, 32'h10, 32'h0, 32'hFFFFFFEF, 0);
        do_main(0, 3'd4, 32'h11, 32'h0, 32'h000000BE, 0);
        do_main(0, 3'd0, 32'h12, 32'h0, 32'hFFFFFFAD, 0);

        // halfwords
        do_main(1, 3'd2, 32'h20, 32'hCAFEBABE, 32'h0, 0);
        do_main(1, 3'd1, 32'h22, 32'h12347FFF, 32'h0, 0);
        do_main(0, 3'd1, 32'h22, 32'h0, 32'h00007FFF, 0);
        do_main(0, 3'd2, 32'h20, 32'h0, 32'h7FFFBABE, 0);
        do_main(1, 3'd1, 32'h22, 32'h00008001, 32'h0, 0);
        do_main(0, 3'd1, 32'h22, 32'h0, 32'hFFFF8001, 0);
        do_main(0, 3'd5, 32'h22, 32'h0, 32'h00008001, 0);
        do_main(0, 3'd1, 32'h20, 32'h0, 32'hFFFFBABE, 0);
        do_main(0, 3'd5, 32'h20, 32'h0, 32'h0000BABE, 0);
        do_main(1, 3'd1, 32'h20, 32'h5A5A1234, 32'h0, 0);
        do_main(0, 3'd2, 32'h20, 32'h0, 32'h80011234, 0);

        // errors
        do_main(0, 3'd2, 32'h11, 32'h0, 32'h0, 1);
        do_main(1, 3'd2, 32'h12, 32'h12345678, 32'h0, 1);
        do_main(0, 3'd2, 32'h10, 32'h0, 32'hA5ADBEEF, 0);
        do_main(0, 3'd3, 32'h10, 32'h0, 32'h0, 1);
        do_main(1, 3'd4, 32'h10, 32'h000000FF, 32'h0, 1);
        do_main(1, 3'd5, 32'h20, 32'h0000FFFF, 32'h0, 1);
        do_main(0, 3'd2, 32'h10, 32'h0, 32'hA5ADBEEF, 0);
        do_main(0, 3'd5, 32'h21, 32'h0, 32'h0, 1);
        do_main(1, 3'd1, 32'h23, 32'h0000FFFF, 32'h0, 1);
        do_main(0, 3'd2, 32'h20, 32'h0, 32'h80011234, 0);
        do_main(0, 3'd6, 32'h20, 32'h0, 32'h0, 1);
        do_main(0, 3'd7, 32'h20, 32'h0, 32'h0, 1);

        // address wrap
        do_main(1, 3'd2, 32'h1000_0010, 32'h0BADF00D, 32'h0, 0);
        do_main(0, 3'd2, 32'h10, 32'h0, 32'h0BADF00D, 0);
        do_main(0, 3'd2, 32'hFFFF_F010, 32'h0, 32'h0BADF00D, 0);

        // latency sweep
        do_sweep(1, 3'd2, 32'h4, 32'h13579BDF, 32'h0);
        do_sweep(0, 3'd2, 32'h4, 32'h0, 32'h13579BDF);
        do_sweep(0, 3'd0, 32'h7, 32'h0, 32'h00000013);

        // reset during the first BUSY cycle of a store
        do_main(1, 3'd2, 32'h30, 32'h11223344, 32'h0, 0);
        do_main(0, 3'd2, 32'h30, 32'h0, 32'h11223344, 0);
        @(negedge clk);
        bus0.mem_we_i = 1'b1; bus0.mem_size_i = 3'd2; bus0.mem_addr_i = 32'h30; bus0.mem_wd_i = 32'h55555555;
        bus0.mem_req_i = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        bus0.mem_req_i = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        do_main(0, 3'd2, 32'h30, 32'h0, 32'h11223344, 0);

        // req held through RESP into the next request
        do_main(1, 3'd2, 32'h40, 32'hA1B2C3D4, 32'h0, 0, 1'b1);
        do_main(0, 3'd2, 32'h40, 32'h0, 32'hA1B2C3D4, 0, 1'b1);
        do_main(0, 3'd4, 32'h41, 32'h0, 32'h000000C3, 0);

        repeat (3) @(negedge clk);
        done = 1'b1;
    end

endmodule
